// File: rtl/sigcorrelate_pkg.sv
// rtl/sigcorrelate_pkg.sv - shared correlator parameters and derived widths
package sigcorrelate_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TRATE = 30;
    localparam int DEF_COUNT = 15;

    function automatic int calc_tbits(input int trate);
        return $clog2(trate);
    endfunction

    function automatic int calc_nbits(input int width);
        return $clog2(width);
    endfunction

    // Each sample adds at most 2 to an accumulator, so 2*COUNT is the ceiling.
    function automatic int calc_obits(input int count);
        return $clog2(2 * count + 1);
    endfunction

    typedef struct packed {
        logic valid;
        logic start;
        logic fin;
        logic last;
    } stage_ctl_t;

endpackage

// File: rtl/sigcorrelate_if.sv
// rtl/sigcorrelate_if.sv - sample stream in, block result stream out
interface sigcorrelate_if import sigcorrelate_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TBITS = calc_tbits(DEF_TRATE),
    parameter int OBITS = calc_obits(DEF_COUNT)
);
    logic             valid_i;
    logic             first_i;
    logic             last_i;
    logic [TBITS-1:0] taddr_i;
    logic [WIDTH-1:0] idata_i;
    logic [WIDTH-1:0] qdata_i;

    logic             valid_o;
    logic             last_o;
    logic [TBITS-1:0] taddr_o;
    logic [OBITS-1:0] re_o;
    logic [OBITS-1:0] im_o;
    logic             err_o;

    modport master (
        output valid_i, first_i, last_i, taddr_i, idata_i, qdata_i,
        input  valid_o, last_o, taddr_o, re_o, im_o, err_o
    );

    modport slave (
        input  valid_i, first_i, last_i, taddr_i, idata_i, qdata_i,
        output valid_o, last_o, taddr_o, re_o, im_o, err_o
    );
endinterface

// File: rtl/sigselect.sv
// rtl/sigselect.sv - per-timeslice antenna tap lookup and registered I/Q bit pick
module sigselect import sigcorrelate_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TRATE = DEF_TRATE,
    parameter int TBITS = calc_tbits(TRATE),
    parameter int NBITS = calc_nbits(WIDTH),
    parameter logic [TRATE*NBITS-1:0] ATAPS = '0,
    parameter logic [TRATE*NBITS-1:0] BTAPS = '0
) (
    input  logic             vis_clk,
    input  logic             reset_n,
    input  logic [TBITS-1:0] taddr,
    input  logic [WIDTH-1:0] idata,
    input  logic [WIDTH-1:0] qdata,
    output logic             ia,
    output logic             qa,
    output logic             ib,
    output logic             qb
);
    logic [NBITS-1:0] a_idx;
    logic [NBITS-1:0] b_idx;

    always_comb begin
        a_idx = NBITS'(ATAPS >> (int'(taddr) * NBITS));
        b_idx = NBITS'(BTAPS >> (int'(taddr) * NBITS));
    end

    always_ff @(posedge vis_clk or negedge reset_n) begin
        if (!reset_n) begin
            ia <= 1'b0;
            qa <= 1'b0;
            ib <= 1'b0;
            qb <= 1'b0;
        end else begin
            ia <= idata[a_idx];
            qa <= qdata[a_idx];
            ib <= idata[b_idx];
            qb <= qdata[b_idx];
        end
    end
endmodule

// File: rtl/sigcorrelate.sv
// rtl/sigcorrelate.sv - 1-bit IQ correlator accumulating COUNT-sample timeslice blocks
module sigcorrelate import sigcorrelate_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TRATE = DEF_TRATE,
    parameter int COUNT = DEF_COUNT,
    parameter logic [TRATE*calc_nbits(WIDTH)-1:0] ATAPS = '0,
    parameter logic [TRATE*calc_nbits(WIDTH)-1:0] BTAPS = '0
) (
    input  logic vis_clk,
    input  logic reset_n,
    sigcorrelate_if.slave bus
);
    localparam int TBITS = calc_tbits(TRATE);
    localparam int OBITS = calc_obits(COUNT);
    localparam int CBITS = $clog2(COUNT + 1);

    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] pos;
    logic [TBITS-1:0] blk_taddr;
    logic             mid, take, start, fin, bad;

    stage_ctl_t       s1_ctl;
    logic [TBITS-1:0] s1_taddr;
    logic             ia, qa, ib, qb;
    logic [1:0]       re_inc, im_inc;

    logic [OBITS-1:0] re_acc, im_acc;
    logic             s2_fin, s2_last;
    logic [TBITS-1:0] s2_taddr;

    // Classify the incoming cycle against the block in progress.
    always_comb begin
        mid   = (cnt != '0);
        take  = 1'b0;
        start = 1'b0;
        fin   = 1'b0;
        bad   = 1'b0;
        pos   = '0;
        if (!bus.valid_i) begin
            bad = mid;
        end else if (mid && !bus.first_i && (bus.taddr_i != blk_taddr)) begin
            bad = 1'b1;
        end else begin
            take  = 1'b1;
            start = bus.first_i || !mid;
            pos   = start ? '0 : cnt;
            fin   = (pos == CBITS'(COUNT - 1));
            bad   = (mid && bus.first_i) || (bus.last_i && !fin);
        end
    end

    always_ff @(posedge vis_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            blk_taddr <= '0;
            bus.err_o <= 1'b0;
            s1_ctl    <= '0;
            s1_taddr  <= '0;
        end else begin
            cnt       <= (!take || fin) ? '0 : pos + 1'b1;
            if (start) blk_taddr <= bus.taddr_i;
            bus.err_o <= bad;
            s1_ctl    <= '{valid: take, start: start, fin: fin, last: bus.last_i && fin};
            s1_taddr  <= bus.taddr_i;
        end
    end

    sigselect #(
        .WIDTH(WIDTH),
        .TRATE(TRATE),
        .ATAPS(ATAPS),
        .BTAPS(BTAPS)
    ) u_select (
        .vis_clk(vis_clk),
        .reset_n(reset_n),
        .taddr  (bus.taddr_i),
        .idata  (bus.idata_i),
        .qdata  (bus.qdata_i),
        .ia     (ia),
        .qa     (qa),
        .ib     (ib),
        .qb     (qb)
    );

    always_comb begin
        re_inc = {1'b0, ia ~^ ib} + {1'b0, qa ~^ qb};
        im_inc = {1'b0, qa ~^ ib} + {1'b0, ia ^ qb};
    end

    // A start sample overwrites rather than adds, so blocks chain with no bubble.
    always_ff @(posedge vis_clk or negedge reset_n) begin
        if (!reset_n) begin
            re_acc   <= '0;
            im_acc   <= '0;
            s2_fin   <= 1'b0;
            s2_last  <= 1'b0;
            s2_taddr <= '0;
        end else begin
            if (s1_ctl.valid) begin
                re_acc <= (s1_ctl.start ? '0 : re_acc) + OBITS'(re_inc);
                im_acc <= (s1_ctl.start ? '0 : im_acc) + OBITS'(im_inc);
            end
            s2_fin  <= s1_ctl.valid && s1_ctl.fin;
            s2_last <= s1_ctl.valid && s1_ctl.last;
            if (s1_ctl.valid && s1_ctl.fin) s2_taddr <= s1_taddr;
        end
    end

    always_ff @(posedge vis_clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.valid_o <= 1'b0;
            bus.last_o  <= 1'b0;
            bus.taddr_o <= '0;
            bus.re_o    <= '0;
            bus.im_o    <= '0;
        end else begin
            bus.valid_o <= s2_fin;
            bus.last_o  <= s2_fin && s2_last;
            if (s2_fin) begin
                bus.taddr_o <= s2_taddr;
                bus.re_o    <= re_acc;
                bus.im_o    <= im_acc;
            end
        end
    end
endmodule

// File: tb/tb_sigcorrelate.sv
// tb/tb_sigcorrelate.sv - directed testbench for sigcorrelate
module tb_sigcorrelate;
    localparam int WIDTH = 4;
    localparam int TRATE = 2;
    localparam int COUNT = 3;
    localparam int TBITS = 1;
    localparam int OBITS = 3;
    localparam logic [3:0] ATAPS = {2'd1, 2'd0};
    localparam logic [3:0] BTAPS = {2'd3, 2'd2};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;
    logic [63:0] mon[$];

    sigcorrelate_if #(.WIDTH(WIDTH), .TBITS(TBITS), .OBITS(OBITS)) bus ();

    sigcorrelate #(
        .WIDTH(WIDTH), .TRATE(TRATE), .COUNT(COUNT), .ATAPS(ATAPS), .BTAPS(BTAPS)
    ) dut (
        .vis_clk(clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pk(input int c, input int re, input int im, input int t, input int l);
        return {32'(c), 8'(re), 8'(im), 8'(t), 8'(l)};
    endfunction

    always @(posedge clk) begin
        #1;
        if (bus.valid_o === 1'b1)
            mon.push_back(pk(cyc, int'(bus.re_o), int'(bus.im_o), int'(bus.taddr_o), int'(bus.last_o)));
        if (bus.err_o === 1'b1) err_seen++;
    end

    task automatic send(input logic v, input logic f, input logic l, input logic t,
                        input logic [3:0] i, input logic [3:0] q, output int acc);
        @(negedge clk);
        bus.valid_i = v;
        bus.first_i = f;
        bus.last_i  = l;
        bus.taddr_i = t;
        bus.idata_i = i;
        bus.qdata_i = q;
        acc = cyc + 1;
    endtask

    task automatic idle(input int n);
        int a;
        for (int k = 0; k < n; k++) send(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, a);
    endtask

    task automatic send_frame(input logic [3:0] i0, input logic [3:0] q0,
                              input logic [3:0] i1, input logic [3:0] q1,
                              output int e0, output int e1);
        int a;
        for (int k = 0; k < 6; k++) begin
            send(1'b1, k == 0, k == 5, k >= 3, (k >= 3) ? i1 : i0, (k >= 3) ? q1 : q0, a);
            if (k == 2) e0 = a;
            if (k == 5) e1 = a;
        end
    endtask

    task automatic clear_mon();
        mon.delete();
        err_seen = 0;
    endtask

    task automatic test_reset();
        bus.valid_i = 0; bus.first_i = 0; bus.last_i = 0;
        bus.taddr_i = 0; bus.idata_i = 0; bus.qdata_i = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.valid_o, bus.last_o, bus.taddr_o, bus.re_o, bus.im_o, bus.err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b l=%b t=%0d re=%0d im=%0d e=%b want all 0",
                     bus.valid_o, bus.last_o, bus.taddr_o, bus.re_o, bus.im_o, bus.err_o);
        end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int e0, e1;
        logic [63:0] exp[$];
        clear_mon();
        send_frame(4'hF, 4'hF, 4'hF, 4'hF, e0, e1);
        idle(5);
        exp = '{pk(e0 + 2, 6, 3, 0, 0), pk(e1 + 2, 6, 3, 1, 1)};
        checks++;
        if (mon.size() != exp.size()) begin
            errors++; $display("FAIL basic_count got %0d want %0d", mon.size(), exp.size());
        end
        for (int k = 0; k < exp.size() && k < mon.size(); k++) begin
            checks++;
            if (mon[k] !== exp[k]) begin
                errors++; $display("FAIL basic_res%0d got %h want %h", k, mon[k], exp[k]);
            end
        end
        checks++;
        if (err_seen != 0) begin errors++; $display("FAIL basic_err got %0d want 0", err_seen); end
    endtask

    task automatic test_invert();
        int e0, e1;
        logic [63:0] exp[$];
        clear_mon();
        send_frame(4'b1011, 4'hF, 4'hF, 4'hF, e0, e1);
        idle(5);
        exp = '{pk(e0 + 2, 3, 0, 0, 0), pk(e1 + 2, 6, 3, 1, 1)};
        checks++;
        if (mon.size() != exp.size()) begin
            errors++; $display("FAIL invert_count got %0d want %0d", mon.size(), exp.size());
        end
        for (int k = 0; k < exp.size() && k < mon.size(); k++) begin
            checks++;
            if (mon[k] !== exp[k]) begin
                errors++; $display("FAIL invert_res%0d got %h want %h", k, mon[k], exp[k]);
            end
        end
        checks++;
        if ({bus.valid_o, bus.re_o, bus.im_o, bus.taddr_o} !== {1'b0, 3'd6, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL hold_outputs got v=%b re=%0d im=%0d t=%0d want v=0 re=6 im=3 t=1",
                     bus.valid_o, bus.re_o, bus.im_o, bus.taddr_o);
        end
    endtask

    task automatic test_drop();
        int a, e0, e1;
        logic [63:0] exp[$];
        clear_mon();
        send(1, 1, 0, 0, 4'hF, 4'hF, a);
        send(1, 0, 0, 0, 4'hF, 4'hF, a);
        send(0, 0, 0, 0, 4'hF, 4'hF, a);
        for (int k = 0; k < 6; k++) begin
            send(1, 0, k == 5, k >= 3, 4'hF, 4'hF, a);
            if (k == 2) e0 = a;
            if (k == 5) e1 = a;
        end
        idle(5);
        exp = '{pk(e0 + 2, 6, 3, 0, 0), pk(e1 + 2, 6, 3, 1, 1)};
        checks++;
        if (mon.size() != exp.size()) begin
            errors++; $display("FAIL drop_count got %0d want %0d", mon.size(), exp.size());
        end
        for (int k = 0; k < exp.size() && k < mon.size(); k++) begin
            checks++;
            if (mon[k] !== exp[k]) begin
                errors++; $display("FAIL drop_res%0d got %h want %h", k, mon[k], exp[k]);
            end
        end
        checks++;
        if (err_seen != 1) begin errors++; $display("FAIL drop_err got %0d want 1", err_seen); end
    endtask

    task automatic test_back_to_back();
        int a0, a1, b0, b1;
        logic [63:0] exp[$];
        clear_mon();
        send_frame(4'hF, 4'hF, 4'hF, 4'hF, a0, a1);
        send_frame(4'b1011, 4'hF, 4'hF, 4'hF, b0, b1);
        idle(5);
        exp = '{pk(a0 + 2, 6, 3, 0, 0), pk(a1 + 2, 6, 3, 1, 1),
                pk(b0 + 2, 3, 0, 0, 0), pk(b1 + 2, 6, 3, 1, 1)};
        checks++;
        if (mon.size() != exp.size()) begin
            errors++; $display("FAIL b2b_count got %0d want %0d", mon.size(), exp.size());
        end
        for (int k = 0; k < exp.size() && k < mon.size(); k++) begin
            checks++;
            if (mon[k] !== exp[k]) begin
                errors++; $display("FAIL b2b_res%0d got %h want %h", k, mon[k], exp[k]);
            end
        end
        checks++;
        if (b1 - a0 != 9) begin errors++; $display("FAIL b2b_spacing got %0d want 9", b1 - a0); end
        checks++;
        if (err_seen != 0) begin errors++; $display("FAIL b2b_err got %0d want 0", err_seen); end
    endtask

    task automatic test_reset_mid();
        int a, e0, e1;
        logic [63:0] exp[$];
        clear_mon();
        send(1, 1, 0, 0, 4'hF, 4'hF, a);
        send(1, 0, 0, 0, 4'hF, 4'hF, a);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.valid_o, bus.last_o, bus.taddr_o, bus.re_o, bus.im_o, bus.err_o} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got re=%0d im=%0d t=%0d want 0", bus.re_o, bus.im_o, bus.taddr_o);
        end
        bus.valid_i = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send_frame(4'hF, 4'hF, 4'hF, 4'hF, e0, e1);
        idle(5);
        exp = '{pk(e0 + 2, 6, 3, 0, 0), pk(e1 + 2, 6, 3, 1, 1)};
        checks++;
        if (mon.size() != exp.size()) begin
            errors++; $display("FAIL rstmid_count got %0d want %0d", mon.size(), exp.size());
        end
        for (int k = 0; k < exp.size() && k < mon.size(); k++) begin
            checks++;
            if (mon[k] !== exp[k]) begin
                errors++; $display("FAIL rstmid_res%0d got %h want %h", k, mon[k], exp[k]);
            end
        end
        checks++;
        if (err_seen != 0) begin errors++; $display("FAIL rstmid_err got %0d want 0", err_seen); end
    endtask

    task automatic test_first_mid();
        int a, e0, e1;
        logic [63:0] exp[$];
        clear_mon();
        send(1, 1, 0, 0, 4'hF, 4'hF, a);
        send(1, 0, 0, 0, 4'hF, 4'hF, a);
        send(1, 1, 0, 0, 4'b1011, 4'hF, a);
        send(1, 0, 0, 0, 4'hF, 4'hF, a);
        send(1, 0, 0, 0, 4'hF, 4'hF, e0);
        for (int k = 0; k < 3; k++) send(1, 0, k == 2, 1, 4'hF, 4'hF, e1);
        idle(5);
        exp = '{pk(e0 + 2, 5, 2, 0, 0), pk(e1 + 2, 6, 3, 1, 1)};
        checks++;
        if (mon.size() != exp.size()) begin
            errors++; $display("FAIL firstmid_count got %0d want %0d", mon.size(), exp.size());
        end
        for (int k = 0; k < exp.size() && k < mon.size(); k++) begin
            checks++;
            if (mon[k] !== exp[k]) begin
                errors++; $display("FAIL firstmid_res%0d got %h want %h", k, mon[k], exp[k]);
            end
        end
        checks++;
        if (err_seen != 1) begin errors++; $display("FAIL firstmid_err got %0d want 1", err_seen); end
    endtask

    task automatic test_last_early();
        int a;
        clear_mon();
        send(1, 1, 0, 0, 4'hF, 4'hF, a);
        send(1, 0, 1, 0, 4'hF, 4'hF, a);
        send(1, 0, 0, 0, 4'hF, 4'hF, a);
        for (int k = 0; k < 3; k++) send(1, 0, k == 2, 1, 4'hF, 4'hF, a);
        idle(5);
        checks++;
        if (err_seen != 1) begin errors++; $display("FAIL lastearly_err got %0d want 1", err_seen); end
        checks++;
        if (mon.size() != 2) begin errors++; $display("FAIL lastearly_count got %0d want 2", mon.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invert();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_first_mid();
        test_last_early();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sigcorrelate.md
SIGCORRELATE -- requirements
Module: sigcorrelate

Interface
REQ-001 WIDTH, 32, number of antenna IQ signal bits per sample.
REQ-002 TRATE, 30, timeslices per frame; TBITS = clog2(TRATE).
REQ-003 COUNT, 15, consecutive samples per timeslice block; OBITS = clog2(2*COUNT+1).
REQ-004 ATAPS, 0, packed TRATE x NBITS antenna-A indices (NBITS = clog2(WIDTH)); entry t at bits [t*NBITS +: NBITS].
REQ-005 BTAPS, 0, packed TRATE x NBITS antenna-B indices, same layout as ATAPS.
REQ-006 vis_clk  in  1  sole clock; all state on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 valid_i  in  1  sample strobe from the signal buffer stream.
REQ-009 first_i  in  1  first sample of a frame.
REQ-010 last_i  in  1  final sample of a frame (last sample of timeslice TRATE-1).
REQ-011 taddr_i  in  TBITS  timeslice index, constant across each COUNT-sample block.
REQ-012 idata_i / qdata_i  in  WIDTH each  1-bit in-phase / quadrature sign per antenna.
REQ-013 valid_o  out  1  one-cycle result strobe.
REQ-014 last_o  out  1  result is the final timeslice of the frame.
REQ-015 taddr_o  out  TBITS  timeslice of the result.
REQ-016 re_o / im_o  out  OBITS each  real / imaginary agreement counts.
REQ-017 err_o  out  1  one-cycle protocol-error strobe.

Function
REQ-018 For accepted sample (valid_i=1): a = idx ATAPS[taddr_i], b = BTAPS[taddr_i]; bit selection registered in stage 1.
REQ-019 Stage 2 adds (Ia xnor Ib)+(Qa xnor Qb) to re accumulator and (Qa xnor Ib)+(Ia xor Qb) to im accumulator, unsigned, OBITS wide; no overflow possible by construction.
REQ-020 Internal sample counter (0..COUNT-1) SHALL clear on first_i and after each completed block; a block completes when counter reaches COUNT-1 on an accepted sample.
REQ-021 On block completion, valid_o SHALL pulse high one cycle, exactly 2 cycles after the accepting edge of the block's final sample, with re_o/im_o holding the block totals and taddr_o the block's taddr.
REQ-022 Accumulators SHALL restart from the first sample of the next block with no bubble; back-to-back blocks yield valid_o every COUNT cycles.
REQ-023 last_o SHALL equal last_i of the block's final sample, qualified by valid_o; last_i on any non-final sample SHALL raise err_o.
REQ-024 valid_i low mid-block, or taddr_i change mid-block, SHALL discard the partial block (no valid_o), pulse err_o once, and clear the counter.
REQ-025 first_i mid-block SHALL pulse err_o, discard the partial block and start a new block with the current sample.
REQ-026 valid_i low between blocks or between frames is legal: no error, state holds.
REQ-027 re_o, im_o, taddr_o SHALL hold their last result values while valid_o is low.
REQ-028 No backpressure; the block accepts one sample every cycle.

Reset
REQ-029 reset_n low SHALL immediately clear all outputs, accumulators, counter and pipeline valid flags to 0.
REQ-030 Reset asserted mid-block SHALL lose the partial block; after release, the first valid_i sample starts a new block.

Structure
REQ-031 TRATE, COUNT, WIDTH defaults and TBITS/NBITS/OBITS derivations SHALL live in the shared correlator parameter package, reused by the signal buffer.
REQ-032 Tap selection (taddr -> a,b indices -> selected I/Q bits) SHALL be one sub-module, sigselect; accumulation/framing stays in sigcorrelate.

Verification (WIDTH=4, TRATE=2, COUNT=3, ATAPS={t0:0,t1:1}, BTAPS={t0:2,t1:3})
REQ-033 All I=Q=1, one frame of 6 samples with first/last -> two valid_o pulses, re_o=6, im_o=3, taddr_o 0 then 1, last_o only on the second.
REQ-034 Antenna 2 I inverted vs antenna 0 for t0 block, others 1 -> re_o=3, im_o=0 for taddr 0.
REQ-035 valid_i dropped after sample 2 of block 0 -> err_o pulses once, no valid_o for that block; next full block reports normally.
REQ-036 Two frames back-to-back with no gap -> valid_o every 3 cycles, 2-cycle latency after each block end, no err_o.
REQ-037 reset_n asserted mid-block, released, full frame applied -> outputs 0 during reset, then results identical to REQ-033.
REQ-038 first_i asserted on sample 2 of a block -> err_o pulse, new block counted from that sample, valid_o 2 cycles after its third sample.
